// File: rtl/dvp_ctrl_pkg.sv
// ============================================================================
// Module      : dvp_ctrl_pkg
// Description : Shared state codes, default delays and a timer sizing helper
//               for the DVP capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvp_ctrl_pkg;

  // Sequencer state codes; also exported on o_state for status/debug
  localparam logic [2:0] C_ST_OFF  = 3'd0;
  localparam logic [2:0] C_ST_PWUP = 3'd1;
  localparam logic [2:0] C_ST_RSTW = 3'd2;
  localparam logic [2:0] C_ST_IDLE = 3'd3;
  localparam logic [2:0] C_ST_ARM  = 3'd4;
  localparam logic [2:0] C_ST_CAPT = 3'd5;

  typedef enum logic [2:0] {
    ST_OFF  = C_ST_OFF,
    ST_PWUP = C_ST_PWUP,
    ST_RSTW = C_ST_RSTW,
    ST_IDLE = C_ST_IDLE,
    ST_ARM  = C_ST_ARM,
    ST_CAPT = C_ST_CAPT
  } seq_state_e;

  // Default sensor power-up delays at a 100 MHz AXI clock
  localparam int unsigned C_T_PWDN_CYCLES_DEF  = 100000;   // 1 ms
  localparam int unsigned C_T_RESET_CYCLES_DEF = 2000000;  // 20 ms
  localparam int unsigned C_FRAME_CNT_W_DEF    = 16;

  // Counter width able to hold (max delay - 1); never narrower than one bit
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_capture_sequencer_if.sv
// ============================================================================
// Module      : dvp_capture_sequencer_if
// Description : Control/status bundle between the register file / pads and
//               the capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dvp_capture_sequencer_if #(
  parameter int unsigned P_FRAME_CNT_WIDTH = 16
);

  logic                         i_enable;
  logic                         i_start;
  logic                         i_stop;
  logic [P_FRAME_CNT_WIDTH-1:0] i_num_frames;
  logic                         i_vsync;
  logic                         o_dvp_pwdn;
  logic                         o_dvp_resetb;
  logic                         o_capture_en;
  logic                         o_ready;
  logic                         o_busy;
  logic                         o_done;
  logic [P_FRAME_CNT_WIDTH-1:0] o_frame_cnt;
  logic [2:0]                   o_state;

  // Register file / sensor side: drives requests, observes status
  modport master (
    output i_enable, i_start, i_stop, i_num_frames, i_vsync,
    input  o_dvp_pwdn, o_dvp_resetb, o_capture_en, o_ready, o_busy,
           o_done, o_frame_cnt, o_state
  );

  // Sequencer side
  modport slave (
    input  i_enable, i_start, i_stop, i_num_frames, i_vsync,
    output o_dvp_pwdn, o_dvp_resetb, o_capture_en, o_ready, o_busy,
           o_done, o_frame_cnt, o_state
  );

endinterface

`default_nettype wire

// File: rtl/dvp_seq_timer.sv
// ============================================================================
// Module      : dvp_seq_timer
// Description : Clearable up-counter with a terminal-count compare, shared by
//               the PWDN and RESETB wait phases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_seq_timer
  import dvp_ctrl_pkg::*;
#(
  parameter int unsigned P_T_PWDN_CYCLES  = C_T_PWDN_CYCLES_DEF,
  parameter int unsigned P_T_RESET_CYCLES = C_T_RESET_CYCLES_DEF,
  localparam int unsigned C_W = timer_width(P_T_PWDN_CYCLES, P_T_RESET_CYCLES)
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  input  wire logic           i_clr,
  input  wire logic           i_inc,
  input  wire logic [C_W-1:0] i_tc_val,
  output logic                o_tc
);

  logic [C_W-1:0] count_q;

  // Count up while enabled; clear has priority so a phase change restarts at 0
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count_q <= '0;
    end else if (i_inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_tc = (count_q == i_tc_val);

endmodule

`default_nettype wire

// File: rtl/dvp_capture_sequencer.sv
// ============================================================================
// Module      : dvp_capture_sequencer
// Description : Sensor power-up sequencing and frame-aligned capture gating
//               for the DVP camera datapath (single i_axi_clk domain).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_capture_sequencer
  import dvp_ctrl_pkg::*;
#(
  parameter int unsigned P_T_PWDN_CYCLES   = C_T_PWDN_CYCLES_DEF,
  parameter int unsigned P_T_RESET_CYCLES  = C_T_RESET_CYCLES_DEF,
  parameter int unsigned P_FRAME_CNT_WIDTH = C_FRAME_CNT_W_DEF
) (
  input  wire logic               i_axi_clk,
  input  wire logic               i_axi_rst,
  dvp_capture_sequencer_if.slave  bus
);

  localparam int unsigned    C_TMR_W    = timer_width(P_T_PWDN_CYCLES, P_T_RESET_CYCLES);
  localparam logic [C_TMR_W-1:0] C_TC_PWDN  = C_TMR_W'(P_T_PWDN_CYCLES - 1);
  localparam logic [C_TMR_W-1:0] C_TC_RESET = C_TMR_W'(P_T_RESET_CYCLES - 1);

  seq_state_e                   state_q, state_d;
  logic                         vsync_q;
  logic [P_FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [P_FRAME_CNT_WIDTH-1:0] num_frames_q, num_frames_d;
  logic                         stop_pending_q, stop_pending_d;
  logic                         done_q, done_d;

  logic                         vsync_rise;
  logic [P_FRAME_CNT_WIDTH-1:0] frame_cnt_inc;
  logic                         tmr_clr;
  logic                         tmr_inc;
  logic [C_TMR_W-1:0]           tmr_tc_val;
  logic                         tmr_tc;

  // vsync_q resets high so a VSYNC already high out of reset is not an edge
  assign vsync_rise    = bus.i_vsync & ~vsync_q;
  assign frame_cnt_inc = frame_cnt_q + 1'b1;

  dvp_seq_timer #(
    .P_T_PWDN_CYCLES  (P_T_PWDN_CYCLES),
    .P_T_RESET_CYCLES (P_T_RESET_CYCLES)
  ) u_timer (
    .i_clk    (i_axi_clk),
    .i_rst    (i_axi_rst),
    .i_clr    (tmr_clr),
    .i_inc    (tmr_inc),
    .i_tc_val (tmr_tc_val),
    .o_tc     (tmr_tc)
  );

  // State, edge-detect history and run bookkeeping registers
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      state_q        <= ST_OFF;
      vsync_q        <= 1'b1;
      frame_cnt_q    <= '0;
      num_frames_q   <= '0;
      stop_pending_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= bus.i_vsync;
      frame_cnt_q    <= frame_cnt_d;
      num_frames_q   <= num_frames_d;
      stop_pending_q <= stop_pending_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic; loss of enable overrides every other request
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    num_frames_d   = num_frames_q;
    stop_pending_d = stop_pending_q;
    done_d         = 1'b0;
    tmr_clr        = 1'b0;
    tmr_inc        = 1'b0;
    tmr_tc_val     = C_TC_PWDN;

    if (!bus.i_enable) begin
      state_d = ST_OFF;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_PWUP;
          tmr_clr = 1'b1;
        end
        ST_PWUP: begin
          tmr_inc    = 1'b1;
          tmr_tc_val = C_TC_PWDN;
          if (tmr_tc) begin
            state_d = ST_RSTW;
            tmr_clr = 1'b1;
          end
        end
        ST_RSTW: begin
          tmr_inc    = 1'b1;
          tmr_tc_val = C_TC_RESET;
          if (tmr_tc) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          // A simultaneous stop is meaningless here, so start always wins
          if (bus.i_start) begin
            state_d        = ST_ARM;
            num_frames_d   = bus.i_num_frames;
            frame_cnt_d    = '0;
            stop_pending_d = 1'b0;
          end
        end
        ST_ARM: begin
          if (bus.i_stop) begin
            state_d = ST_IDLE;
          end else if (vsync_rise) begin
            state_d = ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (vsync_rise) begin
            frame_cnt_d = frame_cnt_inc;
            if (((num_frames_q != '0) && (frame_cnt_inc == num_frames_q)) ||
                stop_pending_q || bus.i_stop) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else if (bus.i_stop) begin
            // Finish the frame in flight; end the run at the next boundary
            stop_pending_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  assign bus.o_dvp_pwdn   = (state_q == ST_OFF);
  assign bus.o_dvp_resetb = !((state_q == ST_OFF) || (state_q == ST_PWUP));
  assign bus.o_capture_en = (state_q == ST_CAPT);
  assign bus.o_ready      = (state_q == ST_IDLE);
  assign bus.o_busy       = (state_q == ST_ARM) || (state_q == ST_CAPT);
  assign bus.o_done       = done_q;
  assign bus.o_frame_cnt  = frame_cnt_q;
  assign bus.o_state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_dvp_capture_sequencer.sv
// ============================================================================
// Module      : tb_dvp_capture_sequencer
// Description : Directed self-checking bench for dvp_capture_sequencer with
//               short power-up delays (4 / 8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvp_capture_sequencer;

  localparam int unsigned C_PWDN = 4;
  localparam int unsigned C_RST  = 8;
  localparam int unsigned C_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dvp_capture_sequencer_if #(.P_FRAME_CNT_WIDTH(C_W)) bus ();

  dvp_capture_sequencer #(
    .P_T_PWDN_CYCLES   (C_PWDN),
    .P_T_RESET_CYCLES  (C_RST),
    .P_FRAME_CNT_WIDTH (C_W)
  ) dut (
    .i_axi_clk (clk),
    .i_axi_rst (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise();
    bus.i_vsync = 1'b1;
    tick();
  endtask

  task automatic fall(input int n);
    bus.i_vsync = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pwdn"},   32'(bus.o_dvp_pwdn),   32'd1);
    chk({tag, ".resetb"}, 32'(bus.o_dvp_resetb), 32'd0);
    chk({tag, ".cap"},    32'(bus.o_capture_en), 32'd0);
    chk({tag, ".ready"},  32'(bus.o_ready),      32'd0);
    chk({tag, ".busy"},   32'(bus.o_busy),       32'd0);
    chk({tag, ".done"},   32'(bus.o_done),       32'd0);
    chk({tag, ".cnt"},    32'(bus.o_frame_cnt),  32'd0);
    chk({tag, ".state"},  32'(bus.o_state),      32'd0);
  endtask

  // Enable must already be 1; the first tick is the edge that samples it
  task automatic power_up(input string tag);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("%s.pwdn@%0d", tag, i),   32'(bus.o_dvp_pwdn),   32'd0);
      chk($sformatf("%s.resetb@%0d", tag, i), 32'(bus.o_dvp_resetb), (i >= 5)  ? 32'd1 : 32'd0);
      chk($sformatf("%s.ready@%0d", tag, i),  32'(bus.o_ready),      (i >= 13) ? 32'd1 : 32'd0);
      chk($sformatf("%s.state@%0d", tag, i),  32'(bus.o_state),
          (i < 5) ? 32'd1 : ((i < 13) ? 32'd2 : 32'd3));
    end
  endtask

  task automatic do_start(input logic [C_W-1:0] n);
    bus.i_num_frames = n;
    bus.i_start      = 1'b1;
    tick();
    bus.i_start      = 1'b0;
  endtask

  initial begin
    bus.i_enable     = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_num_frames = '0;
    bus.i_vsync      = 1'b0;

    // 1: reset state and power-up timing
    repeat (2) tick();
    check_reset("rst");
    rst          = 1'b0;
    bus.i_enable = 1'b1;
    power_up("pu");

    // 2: three-frame run, fifth pulse ignored
    do_start(16'd3);
    chk("s2.arm_state", 32'(bus.o_state), 32'd4);
    chk("s2.arm_busy",  32'(bus.o_busy),  32'd1);
    fall(2);
    chk("s2.arm_cap",   32'(bus.o_capture_en), 32'd0);
    rise();
    chk("s2.cap_on",    32'(bus.o_capture_en), 32'd1);
    chk("s2.capt",      32'(bus.o_state),      32'd5);
    fall(3); rise(); fall(3);
    chk("s2.cnt1",      32'(bus.o_frame_cnt),  32'd1);
    rise(); fall(3);
    chk("s2.cnt2",      32'(bus.o_frame_cnt),  32'd2);
    chk("s2.cap_mid",   32'(bus.o_capture_en), 32'd1);
    rise();
    chk("s2.done",      32'(bus.o_done),       32'd1);
    chk("s2.cnt3",      32'(bus.o_frame_cnt),  32'd3);
    chk("s2.cap_off",   32'(bus.o_capture_en), 32'd0);
    chk("s2.idle",      32'(bus.o_state),      32'd3);
    fall(1);
    chk("s2.done_1cyc", 32'(bus.o_done),       32'd0);
    fall(1); rise();
    chk("s2.p5_state",  32'(bus.o_state),      32'd3);
    chk("s2.p5_cap",    32'(bus.o_capture_en), 32'd0);
    chk("s2.p5_cnt",    32'(bus.o_frame_cnt),  32'd3);
    fall(2);

    // 3a: continuous run, stop in the middle of frame 6
    do_start(16'd0);
    chk("s3.arm_cnt",   32'(bus.o_frame_cnt), 32'd0);
    rise(); fall(3);
    for (int f = 0; f < 5; f++) begin
      rise(); fall(3);
    end
    chk("s3.cnt5",      32'(bus.o_frame_cnt), 32'd5);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    chk("s3.stop_cap",  32'(bus.o_capture_en), 32'd1);
    chk("s3.stop_done", 32'(bus.o_done),       32'd0);
    fall(2);
    chk("s3.still_capt", 32'(bus.o_state),     32'd5);
    rise();
    chk("s3.done",      32'(bus.o_done),       32'd1);
    chk("s3.cnt6",      32'(bus.o_frame_cnt),  32'd6);
    chk("s3.idle",      32'(bus.o_state),      32'd3);
    fall(2);

    // 3b: stop coincident with a VSYNC rise ends on that rise
    do_start(16'd0);
    rise(); fall(3); rise(); fall(3);
    bus.i_stop = 1'b1;
    rise();
    bus.i_stop = 1'b0;
    chk("s3b.done",     32'(bus.o_done),      32'd1);
    chk("s3b.cnt",      32'(bus.o_frame_cnt), 32'd2);
    chk("s3b.idle",     32'(bus.o_state),     32'd3);
    fall(2);

    // 4: stop while armed; then start+stop together in IDLE
    do_start(16'd2);
    fall(1);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    chk("s4.idle",      32'(bus.o_state),      32'd3);
    chk("s4.done",      32'(bus.o_done),       32'd0);
    chk("s4.cnt",       32'(bus.o_frame_cnt),  32'd0);
    rise();
    chk("s4.no_cap",    32'(bus.o_capture_en), 32'd0);
    fall(2);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    chk("s4.start_wins", 32'(bus.o_state), 32'd4);
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    chk("s4.back_idle", 32'(bus.o_state), 32'd3);

    // 5: disable during capture aborts, count holds, full power-up again
    do_start(16'd0);
    rise(); fall(2); rise(); fall(2);
    bus.i_enable = 1'b0;
    tick();
    chk("s5.pwdn",      32'(bus.o_dvp_pwdn),   32'd1);
    chk("s5.resetb",    32'(bus.o_dvp_resetb), 32'd0);
    chk("s5.cap",       32'(bus.o_capture_en), 32'd0);
    chk("s5.done",      32'(bus.o_done),       32'd0);
    chk("s5.cnt_hold",  32'(bus.o_frame_cnt),  32'd1);
    chk("s5.state",     32'(bus.o_state),      32'd0);
    tick();
    bus.i_enable = 1'b1;
    power_up("pu2");

    // 6: reset mid-capture with VSYNC high; no false edge afterwards
    do_start(16'd0);
    rise();
    chk("s6.capt",      32'(bus.o_state), 32'd5);
    rst = 1'b1;
    tick();
    check_reset("s6rst");
    rst = 1'b0;
    power_up("pu3");
    do_start(16'd0);
    repeat (3) tick();
    chk("s6.no_false",  32'(bus.o_state),      32'd4);
    chk("s6.no_cap",    32'(bus.o_capture_en), 32'd0);
    fall(1);
    chk("s6.low_arm",   32'(bus.o_state),      32'd4);
    rise();
    chk("s6.real_edge", 32'(bus.o_capture_en), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
